// File: rtl/ma_univ_reg_pkg.sv
// Shared definitions for the universal register: operation mode encodings
// reused by the register itself and by future datapath control blocks.
package ma_univ_reg_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_INC  = 3'b001;
   localparam logic [2:0] MODE_DEC  = 3'b010;
   localparam logic [2:0] MODE_SHL  = 3'b011;
   localparam logic [2:0] MODE_SHR  = 3'b100;
   localparam logic [2:0] MODE_ROTL = 3'b101;
   localparam logic [2:0] MODE_ROTR = 3'b110;
   localparam logic [2:0] MODE_RSVD = 3'b111;

endpackage : ma_univ_reg_pkg

// File: rtl/ma_univ_next.sv
// Combinational next-value and flag logic for the universal register.
// Given the current contents and the selected mode, produces the value the
// register takes when enabled, plus the carry/borrow and serial-out flags.
module ma_univ_next
   import ma_univ_reg_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int SAT   = 0
) (
   input  logic [WIDTH-1:0] qa,
   input  logic [2:0]       mode,
   input  logic             sin,
   output logic [WIDTH-1:0] nxt_q,
   output logic             nxt_cout,
   output logic             nxt_sout
);

   localparam bit          SAT_EN = (SAT != 0);
   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   // One extra bit on each side: bit WIDTH is the carry (inc) or borrow (dec).
   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign sum  = {1'b0, qa} + ONE;
   assign diff = {1'b0, qa} - ONE;

   // Mode decode: arithmetic wraps or clamps, shifts report the exiting bit.
   always_comb begin
      nxt_q    = qa;
      nxt_cout = 1'b0;
      nxt_sout = 1'b0;
      case (mode)
         MODE_INC: begin
            nxt_cout = sum[WIDTH];
            nxt_q    = (SAT_EN && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
         end
         MODE_DEC: begin
            nxt_cout = diff[WIDTH];
            nxt_q    = (SAT_EN && diff[WIDTH]) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
         end
         MODE_SHL: begin
            nxt_q    = {qa[WIDTH-2:0], sin};
            nxt_sout = qa[WIDTH-1];
         end
         MODE_SHR: begin
            nxt_q    = {sin, qa[WIDTH-1:1]};
            nxt_sout = qa[0];
         end
         MODE_ROTL: begin
            nxt_q    = {qa[WIDTH-2:0], qa[WIDTH-1]};
            nxt_sout = qa[WIDTH-1];
         end
         MODE_ROTR: begin
            nxt_q    = {qa[0], qa[WIDTH-1:1]};
            nxt_sout = qa[0];
         end
         default: begin
            // hold and the reserved encoding leave the contents untouched
            nxt_q    = qa;
         end
      endcase
   end

endmodule : ma_univ_next

// File: rtl/ma_univ_reg.sv
// Universal register: parallel load, count up/down (wrapping or saturating),
// shift and rotate, with registered carry/borrow and serial-out flags.
// Priority per edge is load, then enabled mode operation, then hold.
// All outputs come straight from flops; an asynchronous clear forces the
// reset value and zero flags at any time.
module ma_univ_reg
   import ma_univ_reg_pkg::*;
#(
   parameter int          WIDTH     = 4,
   parameter int unsigned RESET_VAL = 0,
   parameter int          SAT       = 0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ld,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] da,
   input  logic             sin,
   output logic [WIDTH-1:0] qa,
   output logic             cout,
   output logic             sout
);

   // Reset value truncated to the register width.
   localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] qa_q, qa_d;
   logic             cout_q, cout_d;
   logic             sout_q, sout_d;

   logic [WIDTH-1:0] nxt_q;
   logic             nxt_cout;
   logic             nxt_sout;

   ma_univ_next #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
   ) u_next (
      .qa       (qa_q),
      .mode     (mode),
      .sin      (sin),
      .nxt_q    (nxt_q),
      .nxt_cout (nxt_cout),
      .nxt_sout (nxt_sout)
   );

   // Load beats enable; flags are event pulses and drop to 0 unless the mode
   // operation itself raises them.
   always_comb begin
      qa_d   = qa_q;
      cout_d = 1'b0;
      sout_d = 1'b0;
      if (ld) begin
         qa_d = da;
      end else if (en) begin
         qa_d   = nxt_q;
         cout_d = nxt_cout;
         sout_d = nxt_sout;
      end
   end

   // Register bank with asynchronous clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         qa_q   <= RST_Q;
         cout_q <= 1'b0;
         sout_q <= 1'b0;
      end else begin
         qa_q   <= qa_d;
         cout_q <= cout_d;
         sout_q <= sout_d;
      end
   end

   assign qa   = qa_q;
   assign cout = cout_q;
   assign sout = sout_q;

endmodule : ma_univ_reg

// File: tb/tb_ma_univ_reg.sv
// Directed bench for ma_univ_reg. Four instances share the control inputs:
//   a: WIDTH=4, RESET_VAL=9, wrapping     b: WIDTH=4, saturating
//   c: WIDTH=8, wrapping                  d: WIDTH=8, saturating
module tb_ma_univ_reg;
  import ma_univ_reg_pkg::*;

  logic       clk;
  logic       clr;
  logic       ld;
  logic       en;
  logic [2:0] mode;
  logic       sin;
  logic [3:0] da4;
  logic [7:0] da8;

  logic [3:0] a_qa, b_qa;
  logic [7:0] c_qa, d_qa;
  logic       a_cout, b_cout, c_cout, d_cout;
  logic       a_sout, b_sout, c_sout, d_sout;

  int checks;
  int errors;

  ma_univ_reg #(.WIDTH(4), .RESET_VAL(9), .SAT(0)) dut_a (
    .clk(clk), .clr(clr), .ld(ld), .en(en), .mode(mode), .da(da4), .sin(sin),
    .qa(a_qa), .cout(a_cout), .sout(a_sout));
  ma_univ_reg #(.WIDTH(4), .RESET_VAL(0), .SAT(1)) dut_b (
    .clk(clk), .clr(clr), .ld(ld), .en(en), .mode(mode), .da(da4), .sin(sin),
    .qa(b_qa), .cout(b_cout), .sout(b_sout));
  ma_univ_reg #(.WIDTH(8), .RESET_VAL(0), .SAT(0)) dut_c (
    .clk(clk), .clr(clr), .ld(ld), .en(en), .mode(mode), .da(da8), .sin(sin),
    .qa(c_qa), .cout(c_cout), .sout(c_sout));
  ma_univ_reg #(.WIDTH(8), .RESET_VAL(0), .SAT(1)) dut_d (
    .clk(clk), .clr(clr), .ld(ld), .en(en), .mode(mode), .da(da8), .sin(sin),
    .qa(d_qa), .cout(d_cout), .sout(d_sout));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [31:0] q, input logic c, input logic s);
    chk({tag, " a.qa"},   32'(a_qa),   q);
    chk({tag, " a.cout"}, 32'(a_cout), 32'(c));
    chk({tag, " a.sout"}, 32'(a_sout), 32'(s));
  endtask

  task automatic chk_b(input string tag, input logic [31:0] q, input logic c, input logic s);
    chk({tag, " b.qa"},   32'(b_qa),   q);
    chk({tag, " b.cout"}, 32'(b_cout), 32'(c));
    chk({tag, " b.sout"}, 32'(b_sout), 32'(s));
  endtask

  task automatic chk_c(input string tag, input logic [31:0] q, input logic c, input logic s);
    chk({tag, " c.qa"},   32'(c_qa),   q);
    chk({tag, " c.cout"}, 32'(c_cout), 32'(c));
    chk({tag, " c.sout"}, 32'(c_sout), 32'(s));
  endtask

  task automatic chk_d(input string tag, input logic [31:0] q, input logic c, input logic s);
    chk({tag, " d.qa"},   32'(d_qa),   q);
    chk({tag, " d.cout"}, 32'(d_cout), 32'(c));
    chk({tag, " d.sout"}, 32'(d_sout), 32'(s));
  endtask

  // driver tasks: one rising edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic e, input logic [2:0] m,
                       input logic [3:0] d4, input logic [7:0] d8, input logic s);
    ld = l; en = e; mode = m; da4 = d4; da8 = d8; sin = s;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b1;
    drive(1'b0, 1'b0, MODE_HOLD, 4'h0, 8'h00, 1'b0);
    #1;
    // reset value visible before any clock edge
    chk_a("rst", 32'h9, 1'b0, 1'b0);
    chk_b("rst", 32'h0, 1'b0, 1'b0);
    chk_c("rst", 32'h00, 1'b0, 1'b0);
    #1 clr = 1'b0;

    // plain load
    drive(1'b1, 1'b0, MODE_HOLD, 4'h4, 8'h04, 1'b0); step();
    chk_a("load4", 32'h4, 1'b0, 1'b0);
    chk_c("load4", 32'h04, 1'b0, 1'b0);

    // load wins over enabled increment
    drive(1'b1, 1'b1, MODE_INC, 4'h3, 8'h03, 1'b0); step();
    chk_a("ld_prio", 32'h3, 1'b0, 1'b0);

    // increment on all-ones: wrap vs saturate
    drive(1'b1, 1'b0, MODE_HOLD, 4'hF, 8'hFF, 1'b0); step();
    chk_a("ldF", 32'hF, 1'b0, 1'b0);
    drive(1'b0, 1'b1, MODE_INC, 4'h0, 8'h00, 1'b0); step();
    chk_a("incF", 32'h0, 1'b1, 1'b0);
    chk_b("incF", 32'hF, 1'b1, 1'b0);
    chk_c("incFF", 32'h00, 1'b1, 1'b0);
    chk_d("incFF", 32'hFF, 1'b1, 1'b0);
    step();
    chk_a("inc0", 32'h1, 1'b0, 1'b0);
    chk_b("incF2", 32'hF, 1'b1, 1'b0);
    chk_c("inc0", 32'h01, 1'b0, 1'b0);

    // decrement on zero: wrap vs saturate
    drive(1'b1, 1'b0, MODE_HOLD, 4'h0, 8'h00, 1'b0); step();
    chk_b("ld0", 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, MODE_DEC, 4'h0, 8'h00, 1'b0); step();
    chk_a("dec0", 32'hF, 1'b1, 1'b0);
    chk_b("dec0", 32'h0, 1'b1, 1'b0);
    chk_c("dec0", 32'hFF, 1'b1, 1'b0);
    chk_d("dec0", 32'h00, 1'b1, 1'b0);
    step();
    chk_a("decF", 32'hE, 1'b0, 1'b0);
    chk_c("decFF", 32'hFE, 1'b0, 1'b0);

    // shift / rotate
    drive(1'b1, 1'b0, MODE_HOLD, 4'b1011, 8'hB6, 1'b0); step();
    chk_a("ldB", 32'hB, 1'b0, 1'b0);
    drive(1'b0, 1'b1, MODE_SHL, 4'h0, 8'h00, 1'b0); step();
    chk_a("shl", 32'h6, 1'b0, 1'b1);
    chk_c("shl", 32'h6C, 1'b0, 1'b1);
    drive(1'b0, 1'b1, MODE_SHR, 4'h0, 8'h00, 1'b1); step();
    chk_a("shr", 32'hB, 1'b0, 1'b0);
    chk_c("shr", 32'hB6, 1'b0, 1'b0);
    drive(1'b0, 1'b1, MODE_ROTL, 4'h0, 8'h00, 1'b0); step();
    chk_a("rotl1", 32'h7, 1'b0, 1'b1);
    chk_c("rotl1", 32'h6D, 1'b0, 1'b1);
    step();
    chk_a("rotl2", 32'hE, 1'b0, 1'b0);
    chk_c("rotl2", 32'hDA, 1'b0, 1'b0);
    step();
    chk_a("rotl3", 32'hD, 1'b0, 1'b1);
    chk_c("rotl3", 32'hB5, 1'b0, 1'b1);
    step();
    chk_a("rotl4", 32'hB, 1'b0, 1'b1);
    chk_c("rotl4", 32'h6B, 1'b0, 1'b1);
    drive(1'b0, 1'b1, MODE_ROTR, 4'h0, 8'h00, 1'b0); step();
    chk_a("rotr", 32'hD, 1'b0, 1'b1);
    chk_c("rotr", 32'hB5, 1'b0, 1'b1);

    // hold, disabled and reserved modes clear the flags
    drive(1'b0, 1'b1, MODE_HOLD, 4'h0, 8'h00, 1'b1); step();
    chk_a("hold", 32'hD, 1'b0, 1'b0);
    drive(1'b0, 1'b0, MODE_SHL, 4'h0, 8'h00, 1'b1); step();
    chk_a("en0", 32'hD, 1'b0, 1'b0);
    chk_c("en0", 32'hB5, 1'b0, 1'b0);
    drive(1'b0, 1'b1, MODE_RSVD, 4'h0, 8'h00, 1'b1); step();
    chk_a("rsvd", 32'hD, 1'b0, 1'b0);
    drive(1'b0, 1'b0, MODE_INC, 4'h0, 8'h00, 1'b0); step();
    chk_a("en0inc", 32'hD, 1'b0, 1'b0);

    // running count interrupted by an asynchronous clear
    drive(1'b1, 1'b0, MODE_HOLD, 4'h0, 8'h00, 1'b0); step();
    drive(1'b0, 1'b1, MODE_INC, 4'h0, 8'h00, 1'b0); step();
    chk_a("cnt1", 32'h1, 1'b0, 1'b0);
    step();
    chk_a("cnt2", 32'h2, 1'b0, 1'b0);
    step();
    chk_a("cnt3", 32'h3, 1'b0, 1'b0);
    chk_c("cnt3", 32'h03, 1'b0, 1'b0);
    #2 clr = 1'b1;
    #1;
    chk_a("aclr", 32'h9, 1'b0, 1'b0);
    chk_c("aclr", 32'h00, 1'b0, 1'b0);
    step();
    chk_a("clr_held", 32'h9, 1'b0, 1'b0);
    clr = 1'b0;
    step();
    chk_a("after_clr", 32'hA, 1'b0, 1'b0);
    chk_c("after_clr", 32'h01, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ma_univ_reg
